// File: rtl/dct_quant_row_if.sv
// Row-level bus between the DCT unit and the quantizer, and from the quantizer
// to the zigzag/entropy stage.
interface dct_quant_row_if;
  localparam int unsigned NLANE = 16;
  localparam int unsigned CW    = 12;
  localparam int unsigned QW    = 8;

  logic                   in_valid;
  logic [NLANE*CW-1:0]    coef_in;
  logic [1:0]             q_level;
  logic                   out_valid;
  logic [NLANE*QW-1:0]    q_out;
  logic [3:0]             out_row;
  logic                   out_sob;
  logic                   out_eob;
  logic [NLANE-1:0]       sat_flag;
  logic [7:0]             blk_cnt;

  modport master (
    output in_valid, coef_in, q_level,
    input  out_valid, q_out, out_row, out_sob, out_eob, sat_flag, blk_cnt
  );

  modport slave (
    input  in_valid, coef_in, q_level,
    output out_valid, q_out, out_row, out_sob, out_eob, sat_flag, blk_cnt
  );
endinterface

// File: rtl/dct_quant_row.sv
// Row quantizer behind the 2-D DCT: position-dependent power-of-two step,
// round-half-away-from-zero, saturation to +/-127, block framing.
// Two register stages, one row per cycle, no back-pressure.
module dct_quant_row (
  input logic           clk,
  input logic           rstn,  // active-high synchronous reset
  dct_quant_row_if.slave bus
);
  // Geometry is fixed by the 16x16 DCT block size.
  localparam int unsigned NLANE = 16;
  localparam int unsigned CW    = 12;
  localparam int unsigned QW    = 8;

  localparam logic [CW-1:0] OneC   = CW'(1);
  localparam logic [QW-1:0] OneQ   = QW'(1);
  localparam logic [CW:0]   SatMax = (CW+1)'((1 << (QW - 1)) - 1);

  // Input-side block state
  logic [3:0]          row_q;
  logic [1:0]          lvl_q;
  logic [1:0]          lvl_eff;

  // Stage 1
  logic                v1_q;
  logic [3:0]          r1_q;
  logic [CW-1:0]       m1_q [NLANE];
  logic [CW-1:0]       m1_d [NLANE];
  logic [3:0]          s1_q [NLANE];
  logic [3:0]          s1_d [NLANE];
  logic [NLANE-1:0]    neg1_q, neg1_d;

  // Stage 2 / outputs
  logic                out_valid_q, sob_q, eob_q;
  logic [NLANE*QW-1:0] q_q, q_d;
  logic [3:0]          row_out_q;
  logic [NLANE-1:0]    sat_q, sat_d;
  logic [7:0]          blk_q;
  logic [CW:0]         t, u;

  // Magnitude, sign and shift per lane; row 0 uses the level seen this cycle.
  always_comb begin
    lvl_eff = (row_q == 4'd0) ? bus.q_level : lvl_q;
    neg1_d  = '0;
    for (int c = 0; c < NLANE; c++) begin
      neg1_d[c] = bus.coef_in[CW*c + CW - 1];
      // 12-bit unsigned magnitude: -2048 maps to 12'h800 without overflow
      m1_d[c]   = neg1_d[c] ? (~bus.coef_in[CW*c +: CW] + OneC) : bus.coef_in[CW*c +: CW];
      s1_d[c]   = {2'b00, lvl_eff} + 4'(({1'b0, row_q} + 5'(c)) >> 2);
    end
  end

  // Row counter, level latch and stage-1 registers.
  always_ff @(posedge clk) begin
    if (rstn) begin
      row_q  <= '0;
      lvl_q  <= '0;
      v1_q   <= 1'b0;
      r1_q   <= '0;
      neg1_q <= '0;
      for (int c = 0; c < NLANE; c++) begin
        m1_q[c] <= '0;
        s1_q[c] <= '0;
      end
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        row_q  <= row_q + 4'd1;
        lvl_q  <= lvl_eff;  // only changes on row 0; rows 1..15 recirculate
        r1_q   <= row_q;
        neg1_q <= neg1_d;
        m1_q   <= m1_d;
        s1_q   <= s1_d;
      end
    end
  end

  // Round, shift, saturate and restore sign per lane.
  always_comb begin
    q_d   = '0;
    sat_d = '0;
    t     = '0;
    u     = '0;
    for (int c = 0; c < NLANE; c++) begin
      t = {1'b0, m1_q[c]} + ((s1_q[c] != 4'd0) ? ((CW+1)'(1) << (s1_q[c] - 4'd1)) : '0);
      u = t >> s1_q[c];
      if (u > SatMax) begin
        u        = SatMax;
        sat_d[c] = 1'b1;
      end
      q_d[QW*c +: QW] = neg1_q[c] ? (~u[QW-1:0] + OneQ) : u[QW-1:0];
    end
  end

  // Output register; data fields hold while idle, framing pulses only with valid.
  always_ff @(posedge clk) begin
    if (rstn) begin
      out_valid_q <= 1'b0;
      sob_q       <= 1'b0;
      eob_q       <= 1'b0;
      q_q         <= '0;
      row_out_q   <= '0;
      sat_q       <= '0;
      blk_q       <= '0;
    end else begin
      out_valid_q <= v1_q;
      sob_q       <= v1_q && (r1_q == 4'd0);
      eob_q       <= v1_q && (r1_q == 4'd15);
      if (v1_q) begin
        q_q       <= q_d;
        row_out_q <= r1_q;
        sat_q     <= sat_d;
        if (r1_q == 4'd15) blk_q <= blk_q + 8'd1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sob   = sob_q;
  assign bus.out_eob   = eob_q;
  assign bus.q_out     = q_q;
  assign bus.out_row   = row_out_q;
  assign bus.sat_flag  = sat_q;
  assign bus.blk_cnt   = blk_q;
endmodule

// File: tb/tb_dct_quant_row.sv
// Self-checking bench for dct_quant_row: random rows against an arithmetic
// reference model, plus directed rounding/saturation/latch/gap/reset cases.
module tb_dct_quant_row;
  typedef struct packed {
    logic         valid;
    logic [127:0] q;
    logic [15:0]  sat;
    logic [3:0]   row;
    logic         sob;
    logic         eob;
    logic [7:0]   blk;
  } exp_t;

  logic clk;
  logic rstn;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cin [16];
  int   mdl_row, mdl_lvl, mdl_blk;
  exp_t pend, ex;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dct_quant_row_if bus ();

  dct_quant_row dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  function automatic int rand_coef();
    case ($urandom_range(0, 7))
      0:       return -2048;
      1:       return 2047;
      2:       return 0;
      3:       return int'($urandom_range(0, 40)) - 20;
      default: return int'($urandom_range(0, 4095)) - 2048;
    endcase
  endfunction

  task automatic fill_rand();
    for (int c = 0; c < 16; c++) cin[c] = rand_coef();
  endtask

  // Drive one cycle, advance the model; ex = what the outputs must show now.
  task automatic cyc(input bit v, input logic [1:0] lvl);
    exp_t nw;
    int   m, s, u;
    nw = '0;
    bus.in_valid = v;
    bus.q_level  = lvl;
    for (int c = 0; c < 16; c++) bus.coef_in[12*c +: 12] = 12'(cin[c]);
    if (v) begin
      if (mdl_row == 0) mdl_lvl = lvl;
      nw.valid = 1'b1;
      nw.row   = 4'(mdl_row);
      nw.sob   = (mdl_row == 0);
      nw.eob   = (mdl_row == 15);
      for (int c = 0; c < 16; c++) begin
        m = (cin[c] < 0) ? -cin[c] : cin[c];
        s = mdl_lvl + (mdl_row + c) / 4;
        u = (m + ((s > 0) ? (1 << (s - 1)) : 0)) / (1 << s);
        if (u > 127) begin
          u         = 127;
          nw.sat[c] = 1'b1;
        end
        nw.q[8*c +: 8] = 8'((cin[c] < 0) ? -u : u);
      end
      if (nw.eob) mdl_blk = (mdl_blk + 1) % 256;
      nw.blk  = 8'(mdl_blk);
      mdl_row = (mdl_row + 1) % 16;
    end
    @(posedge clk);
    @(negedge clk);
    if (pend.valid) ex = pend;
    else begin
      ex.valid = 1'b0;
      ex.sob   = 1'b0;
      ex.eob   = 1'b0;
    end
    pend = nw;
  endtask

  task automatic do_reset();
    rstn         = 1'b1;
    bus.in_valid = 1'b0;
    bus.coef_in  = '0;
    bus.q_level  = 2'd0;
    @(posedge clk);
    @(negedge clk);
    rstn    = 1'b0;
    mdl_row = 0;
    mdl_lvl = 0;
    mdl_blk = 0;
    pend    = '0;
    ex      = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({bus.out_valid, bus.out_sob, bus.out_eob} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctl: got v/s/e=%b%b%b, expected 000", bus.out_valid, bus.out_sob,
               bus.out_eob);
    end
    n_chk++;
    if (bus.q_out !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_q: got %h, expected 0", bus.q_out);
    end
    n_chk++;
    if ({bus.out_row, bus.sat_flag, bus.blk_cnt} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_misc: got row=%0d sat=%h blk=%0d, expected 0/0/0", bus.out_row,
               bus.sat_flag, bus.blk_cnt);
    end
  endtask

  task automatic test_zero_block();
    int nv = 0, ns = 0, ne = 0;
    for (int c = 0; c < 16; c++) cin[c] = 0;
    for (int i = 0; i < 18; i++) begin
      cyc(i < 16, 2'd0);
      nv += int'(bus.out_valid);
      ns += int'(bus.out_sob);
      ne += int'(bus.out_eob);
      n_chk++;
      if ({bus.out_valid, bus.out_sob, bus.out_eob, bus.out_row, bus.blk_cnt} !==
          {ex.valid, ex.sob, ex.eob, ex.row, ex.blk}) begin
        n_fail++;
        $display("FAIL zero_frame @%0t: got v%b s%b e%b r%0d b%0d, expected v%b s%b e%b r%0d b%0d",
                 $time, bus.out_valid, bus.out_sob, bus.out_eob, bus.out_row, bus.blk_cnt,
                 ex.valid, ex.sob, ex.eob, ex.row, ex.blk);
      end
      n_chk++;
      if ({bus.q_out, bus.sat_flag} !== 144'd0) begin
        n_fail++;
        $display("FAIL zero_data @%0t: got q=%h sat=%h, expected 0", $time, bus.q_out,
                 bus.sat_flag);
      end
    end
    n_chk++;
    if (nv != 16 || ns != 1 || ne != 1 || bus.blk_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL zero_counts: got valid=%0d sob=%0d eob=%0d blk=%0d, expected 16/1/1/1", nv,
               ns, ne, bus.blk_cnt);
    end
  endtask

  // Block A (level 0) saturation, block B (level 2) rounding, both checked at row 0.
  task automatic test_round_sat();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 18; i++) begin
        if (i == 0) begin
          for (int c = 0; c < 16; c++) cin[c] = 0;
          if (b == 0) begin
            cin[0] = 100; cin[1] = 200; cin[2] = -300;
          end else begin
            cin[3] = 11; cin[4] = 12; cin[5] = -21;
          end
        end else fill_rand();
        cyc(i < 16, (b == 0) ? 2'd0 : 2'd2);
        n_chk++;
        if ({bus.out_valid, bus.out_sob, bus.out_eob, bus.out_row, bus.blk_cnt,
             bus.q_out, bus.sat_flag} !==
            {ex.valid, ex.sob, ex.eob, ex.row, ex.blk, ex.q, ex.sat}) begin
          n_fail++;
          $display("FAIL round_model @%0t: got v%b r%0d q=%h sat=%h, expected v%b r%0d q=%h sat=%h",
                   $time, bus.out_valid, bus.out_row, bus.q_out, bus.sat_flag, ex.valid, ex.row,
                   ex.q, ex.sat);
        end
        if (i == 1 && b == 0) begin
          n_chk++;
          if ({bus.q_out[23:0], bus.sat_flag} !== {8'h81, 8'd127, 8'd100, 16'h0006}) begin
            n_fail++;
            $display("FAIL sat_lanes: got lanes2..0=%h sat=%h, expected 817f64 0006",
                     bus.q_out[23:0], bus.sat_flag);
          end
        end
        if (i == 1 && b == 1) begin
          n_chk++;
          if ({bus.q_out[47:24], bus.sat_flag} !== {8'hFD, 8'd2, 8'd3, 16'h0000}) begin
            n_fail++;
            $display("FAIL round_lanes: got lanes5..3=%h sat=%h, expected fd0203 0000",
                     bus.q_out[47:24], bus.sat_flag);
          end
        end
      end
    end
  endtask

  task automatic test_level_latch();
    for (int i = 0; i < 18; i++) begin
      fill_rand();
      if (i == 15) cin[15] = -2048;
      cyc(i < 16, (i < 8) ? 2'd3 : 2'd0);
      n_chk++;
      if ({bus.out_valid, bus.out_sob, bus.out_eob, bus.out_row, bus.blk_cnt,
           bus.q_out, bus.sat_flag} !==
          {ex.valid, ex.sob, ex.eob, ex.row, ex.blk, ex.q, ex.sat}) begin
        n_fail++;
        $display("FAIL latch_model @%0t: got v%b r%0d q=%h sat=%h, expected v%b r%0d q=%h sat=%h",
                 $time, bus.out_valid, bus.out_row, bus.q_out, bus.sat_flag, ex.valid, ex.row,
                 ex.q, ex.sat);
      end
      if (i == 16) begin
        n_chk++;
        if ({bus.out_eob, bus.q_out[127:120]} !== {1'b1, 8'hFE}) begin
          n_fail++;
          $display("FAIL latch_lane15: got eob=%b lane15=%h, expected 1 fe", bus.out_eob,
                   bus.q_out[127:120]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    bit vq[$];
    int nrow = 0, ne = 0, blk0;
    blk0 = mdl_blk;
    for (int r = 0; r < 16; r++) begin
      vq.push_back(1'b1);
      if (r == 3 || r == 14) repeat (5) vq.push_back(1'b0);
    end
    vq.push_back(1'b0);
    vq.push_back(1'b0);
    foreach (vq[i]) begin
      fill_rand();
      cyc(vq[i], 2'($urandom_range(0, 3)));
      n_chk++;
      if ({bus.out_valid, bus.out_sob, bus.out_eob, bus.out_row, bus.blk_cnt,
           bus.q_out, bus.sat_flag} !==
          {ex.valid, ex.sob, ex.eob, ex.row, ex.blk, ex.q, ex.sat}) begin
        n_fail++;
        $display("FAIL gaps_model @%0t: got v%b r%0d q=%h sat=%h, expected v%b r%0d q=%h sat=%h",
                 $time, bus.out_valid, bus.out_row, bus.q_out, bus.sat_flag, ex.valid, ex.row,
                 ex.q, ex.sat);
      end
      if (bus.out_valid === 1'b1) begin
        n_chk++;
        if (bus.out_row !== 4'(nrow)) begin
          n_fail++;
          $display("FAIL gaps_row: got %0d, expected %0d", bus.out_row, nrow);
        end
        nrow++;
      end
      ne += int'(bus.out_eob);
    end
    n_chk++;
    if (ne != 1 || nrow != 16 || bus.blk_cnt !== 8'((blk0 + 1) % 256)) begin
      n_fail++;
      $display("FAIL gaps_counts: got eob=%0d rows=%0d blk=%0d, expected 1/16/%0d", ne, nrow,
               bus.blk_cnt, (blk0 + 1) % 256);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 8; i++) begin
      fill_rand();
      cyc(1'b1, 2'd1);
    end
    do_reset();
    n_chk++;
    if ({bus.out_valid, bus.out_sob, bus.out_eob, bus.out_row, bus.sat_flag, bus.blk_cnt,
         bus.q_out} !== '0) begin
      n_fail++;
      $display("FAIL midrst_zero: got v%b r%0d sat=%h blk=%0d q=%h, expected all 0",
               bus.out_valid, bus.out_row, bus.sat_flag, bus.blk_cnt, bus.q_out);
    end
    for (int i = 0; i < 19; i++) begin
      fill_rand();
      cyc(i >= 1 && i <= 16, 2'($urandom_range(0, 3)));
      n_chk++;
      if ({bus.out_valid, bus.out_sob, bus.out_eob, bus.out_row, bus.blk_cnt,
           bus.q_out, bus.sat_flag} !==
          {ex.valid, ex.sob, ex.eob, ex.row, ex.blk, ex.q, ex.sat}) begin
        n_fail++;
        $display("FAIL midrst_model @%0t: got v%b r%0d q=%h sat=%h, expected v%b r%0d q=%h sat=%h",
                 $time, bus.out_valid, bus.out_row, bus.q_out, bus.sat_flag, ex.valid, ex.row,
                 ex.q, ex.sat);
      end
      if (i == 2) begin
        n_chk++;
        if ({bus.out_valid, bus.out_sob, bus.out_row, bus.blk_cnt} !== {2'b11, 4'd0, 8'd0}) begin
          n_fail++;
          $display("FAIL midrst_sob: got v%b s%b r%0d blk%0d, expected v1 s1 r0 blk0",
                   bus.out_valid, bus.out_sob, bus.out_row, bus.blk_cnt);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 256 * 16 + 2; i++) begin
      fill_rand();
      cyc(i < 256 * 16, 2'($urandom_range(0, 3)));
      n_chk++;
      if ({bus.out_valid, bus.out_sob, bus.out_eob, bus.out_row, bus.blk_cnt,
           bus.q_out, bus.sat_flag} !==
          {ex.valid, ex.sob, ex.eob, ex.row, ex.blk, ex.q, ex.sat}) begin
        n_fail++;
        $display("FAIL b2b_model @%0t: got v%b r%0d b%0d q=%h sat=%h, expected v%b r%0d b%0d q=%h sat=%h",
                 $time, bus.out_valid, bus.out_row, bus.blk_cnt, bus.q_out, bus.sat_flag,
                 ex.valid, ex.row, ex.blk, ex.q, ex.sat);
      end
    end
    n_chk++;
    if (bus.blk_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL blk_wrap: got %0d, expected 0", bus.blk_cnt);
    end
  endtask

  task automatic test_random_gaps();
    for (int i = 0; i < 4 * 16 * 2; i++) begin
      fill_rand();
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
      n_chk++;
      if ({bus.out_valid, bus.out_sob, bus.out_eob, bus.out_row, bus.blk_cnt,
           bus.q_out, bus.sat_flag} !==
          {ex.valid, ex.sob, ex.eob, ex.row, ex.blk, ex.q, ex.sat}) begin
        n_fail++;
        $display("FAIL rand_model @%0t: got v%b r%0d b%0d q=%h sat=%h, expected v%b r%0d b%0d q=%h sat=%h",
                 $time, bus.out_valid, bus.out_row, bus.blk_cnt, bus.q_out, bus.sat_flag,
                 ex.valid, ex.row, ex.blk, ex.q, ex.sat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_round_sat();
    test_level_latch();
    test_gaps();
    test_random_gaps();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
